dm_load_unit: RTL and testbench

// - Read-side companion of the byte-enable data memory. Sits in M->W, after the synchronous BRAM_DM read port.
// - Registers load type, address low bits and destination tag at issue.
// - Next cycle, selects byte/halfword/word from BRAM douta, sign/zero extends it, flags misaligned loads (AdEL).
// - Holds its result stable across stalls, even if the BRAM address moves.

---
 rtl/dm_load_unit_pkg.sv | 35 +++
 rtl/dm_load_unit_extend.sv | 28 ++
 rtl/dm_load_unit.sv | 84 ++++++++
 tb/tb_dm_load_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_load_unit_pkg.sv
// Shared load-unit definitions: op codes and the alignment helpers used at issue.
package dm_load_unit_pkg;

  localparam int LD_OP_W = 3;

  typedef logic [LD_OP_W-1:0] ld_op_t;

  localparam ld_op_t LD_LW  = 3'b000;
  localparam ld_op_t LD_LH  = 3'b001;
  localparam ld_op_t LD_LHU = 3'b010;
  localparam ld_op_t LD_LB  = 3'b011;
  localparam ld_op_t LD_LBU = 3'b100;

  function automatic logic ld_legal(input ld_op_t op);
    return (op <= LD_LBU);
  endfunction

  function automatic logic ld_misaligned(input ld_op_t op, input logic [1:0] a);
    case (op)
      LD_LW:         return (a != 2'b00);
      LD_LH, LD_LHU: return a[0];
      default:       return 1'b0;
    endcase
  endfunction

  // Natural alignment used when exceptions are disabled: offending low bits become 0.
  function automatic logic [1:0] ld_align(input ld_op_t op, input logic [1:0] a);
    case (op)
      LD_LW:         return 2'b00;
      LD_LH, LD_LHU: return {a[1], 1'b0};
      default:       return a;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_unit_extend.sv
// Lane select and sign/zero extension of a little-endian BRAM word.
module load_extend
  import dm_load_unit_pkg::*;
(
  input  ld_op_t      op,
  input  logic [1:0]  a,
  input  logic [31:0] dout,
  output logic [31:0] result
);

  logic [7:0]  lane;
  logic [15:0] half;

  always_comb begin
    lane   = dout[{a, 3'b000} +: 8];
    half   = a[1] ? dout[31:16] : dout[15:0];
    result = 32'd0;
    case (op)
      LD_LW:   result = dout;
      LD_LH:   result = {{16{half[15]}}, half};
      LD_LHU:  result = {16'd0, half};
      LD_LB:   result = {{24{lane[7]}}, lane};
      LD_LBU:  result = {24'd0, lane};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// M->W load stage: registers the issued load, extracts from BRAM douta next cycle,
// flags AdEL and keeps the result frozen across stalls.
module dm_load_unit
  import dm_load_unit_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter bit EXC_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  input  logic [2:0]       Op,
  input  logic [31:0]      Addr,
  input  logic [TAG_W-1:0] Tag,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [31:0]      RamDout,
  output logic             RdValid,
  output logic [31:0]      RdData,
  output logic [TAG_W-1:0] RdTag,
  output logic             AdEL,
  output logic [31:0]      BadVAddr
);

  logic             st_valid;
  logic             st_exc;
  ld_op_t           st_op;
  logic [1:0]       st_a;
  logic [31:0]      st_addr;
  logic [TAG_W-1:0] st_tag;
  logic             hold_valid;
  logic [31:0]      hold_data;
  logic [31:0]      ext_data;
  logic             issue;
  logic             mis;

  always_comb begin
    issue = Req & ~Stall & ~Flush & ld_legal(Op);
    mis   = ld_misaligned(Op, Addr[1:0]);
  end

  load_extend u_ext (
    .op     (st_op),
    .a      (st_a),
    .dout   (RamDout),
    .result (ext_data)
  );

  // Flush beats Stall; under Stall the first cycle snapshots douta since the BRAM address may move.
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      st_valid   <= 1'b0;
      st_exc     <= 1'b0;
      st_op      <= LD_LW;
      st_a       <= 2'b00;
      st_addr    <= 32'd0;
      st_tag     <= '0;
      hold_valid <= 1'b0;
      hold_data  <= 32'd0;
    end else if (!Stall) begin
      st_valid   <= issue & ~(EXC_EN & mis);
      st_exc     <= issue & EXC_EN & mis;
      hold_valid <= 1'b0;
      if (issue) begin
        st_op   <= Op;
        st_a    <= EXC_EN ? Addr[1:0] : ld_align(Op, Addr[1:0]);
        st_addr <= Addr;
        st_tag  <= Tag;
      end
    end else if (st_valid && !hold_valid) begin
      hold_data  <= ext_data;
      hold_valid <= 1'b1;
    end
  end

  always_comb begin
    RdValid  = st_valid;
    RdData   = st_valid ? (hold_valid ? hold_data : ext_data) : 32'd0;
    RdTag    = st_valid ? st_tag : '0;
    AdEL     = st_exc;
    BadVAddr = st_exc ? st_addr : 32'd0;
  end

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed bench for dm_load_unit: vector table of single loads plus stall/flush/reset/back-to-back sequences.
module tb_dm_load_unit;

  localparam logic [31:0] RAM = 32'h8765_F0A1;

  logic        Clk = 1'b0;
  logic        Reset, Req, Stall, Flush;
  logic [2:0]  Op;
  logic [31:0] Addr, RamDout;
  logic [4:0]  Tag;

  logic        rd_valid, adel, rd_valid0, adel0;
  logic [31:0] rd_data, badv, rd_data0, badv0;
  logic [4:0]  rd_tag, rd_tag0;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [4:0]  tag;
    logic        valid;
    logic [31:0] data;
    logic        adel;
    logic [31:0] badv;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] b2b[4];

  always #5 Clk = ~Clk;

  dm_load_unit #(.TAG_W(5), .EXC_EN(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr), .Tag(Tag),
    .Stall(Stall), .Flush(Flush), .RamDout(RamDout),
    .RdValid(rd_valid), .RdData(rd_data), .RdTag(rd_tag), .AdEL(adel), .BadVAddr(badv)
  );

  dm_load_unit #(.TAG_W(5), .EXC_EN(1'b0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr), .Tag(Tag),
    .Stall(Stall), .Flush(Flush), .RamDout(RamDout),
    .RdValid(rd_valid0), .RdData(rd_data0), .RdTag(rd_tag0), .AdEL(adel0), .BadVAddr(badv0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] tag);
    Req = 1'b1; Op = op; Addr = addr; Tag = tag;
  endtask

  initial begin
    vecs[0]  = '{3'b011, 32'h0000_0000, 5'd1,  1'b1, 32'hFFFF_FFA1, 1'b0, 32'd0};
    vecs[1]  = '{3'b100, 32'h0000_0001, 5'd2,  1'b1, 32'h0000_00F0, 1'b0, 32'd0};
    vecs[2]  = '{3'b011, 32'h0000_0003, 5'd3,  1'b1, 32'hFFFF_FF87, 1'b0, 32'd0};
    vecs[3]  = '{3'b011, 32'h0000_0002, 5'd4,  1'b1, 32'h0000_0065, 1'b0, 32'd0};
    vecs[4]  = '{3'b001, 32'h0000_0002, 5'd5,  1'b1, 32'hFFFF_8765, 1'b0, 32'd0};
    vecs[5]  = '{3'b010, 32'h0000_0000, 5'd6,  1'b1, 32'h0000_F0A1, 1'b0, 32'd0};
    vecs[6]  = '{3'b001, 32'h0000_0000, 5'd7,  1'b1, 32'hFFFF_F0A1, 1'b0, 32'd0};
    vecs[7]  = '{3'b010, 32'h0000_0002, 5'd8,  1'b1, 32'h0000_8765, 1'b0, 32'd0};
    vecs[8]  = '{3'b000, 32'h0000_0000, 5'd31, 1'b1, 32'h8765_F0A1, 1'b0, 32'd0};
    vecs[9]  = '{3'b000, 32'h0000_1002, 5'd9,  1'b0, 32'd0,         1'b1, 32'h0000_1002};
    vecs[10] = '{3'b001, 32'h0000_2001, 5'd10, 1'b0, 32'd0,         1'b1, 32'h0000_2001};
    vecs[11] = '{3'b101, 32'h0000_0000, 5'd11, 1'b0, 32'd0,         1'b0, 32'd0};
    vecs[12] = '{3'b100, 32'h0000_4003, 5'd12, 1'b1, 32'h0000_0087, 1'b0, 32'd0};
    b2b[0] = 32'h0000_00A1; b2b[1] = 32'h0000_00F0;
    b2b[2] = 32'h0000_0065; b2b[3] = 32'h0000_0087;

    Reset = 1'b1; Req = 1'b0; Op = 3'd0; Addr = 32'd0; Tag = 5'd0;
    Stall = 1'b0; Flush = 1'b0; RamDout = RAM;
    tick(); tick();
    chk("reset_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_data",  rd_data, 32'd0);
    chk("reset_adel",  {31'd0, adel}, 32'd0);
    chk("reset_badv",  badv, 32'd0);
    Reset = 1'b0;

    // Single loads, result checked one cycle after issue
    for (int i = 0; i < 13; i++) begin
      tick();
      issue(vecs[i].op, vecs[i].addr, vecs[i].tag);
      RamDout = RAM;
      tick();
      Req = 1'b0;
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("vec%0d_data", i),  rd_data, vecs[i].data);
      chk($sformatf("vec%0d_tag", i),   {27'd0, rd_tag}, vecs[i].valid ? {27'd0, vecs[i].tag} : 32'd0);
      chk($sformatf("vec%0d_adel", i),  {31'd0, adel}, {31'd0, vecs[i].adel});
      chk($sformatf("vec%0d_badv", i),  badv, vecs[i].badv);
    end

    // LW then a 4-cycle stall, douta goes to 0 and a new Req waits upstream
    tick();
    issue(3'b000, 32'h0000_0100, 5'd7); RamDout = RAM;
    tick();
    issue(3'b100, 32'h0000_0101, 5'd3); Stall = 1'b1;
    #1;
    chk("stall0_data", rd_data, RAM);
    for (int k = 0; k < 3; k++) begin
      tick();
      RamDout = 32'd0;
      #1;
      chk($sformatf("stall%0d_valid", k + 1), {31'd0, rd_valid}, 32'd1);
      chk($sformatf("stall%0d_data", k + 1),  rd_data, RAM);
      chk($sformatf("stall%0d_tag", k + 1),   {27'd0, rd_tag}, 32'd7);
    end
    tick();
    Stall = 1'b0;
    #1;
    chk("stall_release_data", rd_data, RAM);
    tick();
    Req = 1'b0; RamDout = RAM;
    #1;
    chk("replay_data", rd_data, 32'h0000_00F0);
    chk("replay_tag",  {27'd0, rd_tag}, 32'd3);
    tick();
    #1;
    chk("replay_done_valid", {31'd0, rd_valid}, 32'd0);

    // AdEL held by stall, then drops
    issue(3'b000, 32'h0000_1002, 5'd1);
    tick();
    Req = 1'b0; Stall = 1'b1;
    #1;
    chk("adel_stall_a", {31'd0, adel}, 32'd1);
    chk("adel_stall_valid", {31'd0, rd_valid}, 32'd0);
    tick();
    #1;
    chk("adel_stall_b", {31'd0, adel}, 32'd1);
    chk("adel_stall_badv", badv, 32'h0000_1002);
    tick();
    Stall = 1'b0;
    tick();
    #1;
    chk("adel_cleared", {31'd0, adel}, 32'd0);

    // Flush under stall
    issue(3'b000, 32'h0000_0000, 5'd9);
    tick();
    Req = 1'b0; Stall = 1'b1; Flush = 1'b1;
    #1;
    chk("flush_pre_valid", {31'd0, rd_valid}, 32'd1);
    tick();
    Flush = 1'b0;
    #1;
    chk("flush_valid", {31'd0, rd_valid}, 32'd0);
    chk("flush_data",  rd_data, 32'd0);
    chk("flush_adel",  {31'd0, adel}, 32'd0);
    tick();
    Stall = 1'b0;

    // Reset mid-load under stall
    issue(3'b011, 32'h0000_0003, 5'd4);
    tick();
    Req = 1'b0; Stall = 1'b1; Reset = 1'b1;
    #1;
    chk("rst_pre_data", rd_data, 32'hFFFF_FF87);
    tick();
    #1;
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_data",  rd_data, 32'd0);
    chk("rst_tag",   {27'd0, rd_tag}, 32'd0);
    Reset = 1'b0; Stall = 1'b0;

    // Back-to-back LBU, one per cycle
    tick();
    issue(3'b100, 32'h0000_0000, 5'd10);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) begin
        Addr = 32'(k + 1); Tag = 5'(10 + k + 1);
      end else begin
        Req = 1'b0;
      end
      #1;
      chk($sformatf("b2b%0d_valid", k), {31'd0, rd_valid}, 32'd1);
      chk($sformatf("b2b%0d_data", k),  rd_data, b2b[k]);
      chk($sformatf("b2b%0d_tag", k),   {27'd0, rd_tag}, 32'(10 + k));
    end

    // Exceptions disabled: misaligned loads are aligned down
    tick();
    issue(3'b000, 32'h0000_1002, 5'd2);
    tick();
    issue(3'b001, 32'h0000_2001, 5'd5);
    #1;
    chk("noexc_lw_valid", {31'd0, rd_valid0}, 32'd1);
    chk("noexc_lw_data",  rd_data0, RAM);
    chk("noexc_lw_adel",  {31'd0, adel0}, 32'd0);
    chk("noexc_lw_badv",  badv0, 32'd0);
    chk("exc_lw_adel",    {31'd0, adel}, 32'd1);
    tick();
    Req = 1'b0;
    #1;
    chk("noexc_lh_data", rd_data0, 32'hFFFF_F0A1);
    chk("noexc_lh_tag",  {27'd0, rd_tag0}, 32'd5);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
